// File: rtl/residual_stream_pkg.sv
// Shared definitions for the residual_stream block.
//   - Default block geometry and bit budget.
//   - FSM state encoding (FILL -> CALC -> DRAIN).
//   - BITS_W: width of one per-channel bits_required header field.
package residual_stream_pkg;

  localparam int CHANNELS   = 4;   // colour channels per pixel, RGBA, 0 = R
  localparam int CH_W       = 8;   // bits per channel
  localparam int BLOCK_PIX  = 32;  // pixels per compression block
  localparam int BEAT_PIX   = 4;   // pixels per stream beat
  localparam int BIT_BUDGET = 14;  // max summed channel widths for compression

  localparam int BITS_W = $clog2(CH_W);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/residual_stream_ch_width.sv
// ch_width: number of bits needed to represent one channel's value range.
//   diff  in   CH_W     max - min for the channel
//   width out  WIDTH_W  0 when diff == 0, else index of highest set bit + 1
//   skip  out  1        channel is constant (diff == 0)
module ch_width #(
  parameter  int CH_W    = 8,
  localparam int WIDTH_W = $clog2(CH_W + 1)
) (
  input  logic [CH_W-1:0]    diff,
  output logic [WIDTH_W-1:0] width,
  output logic               skip
);

  // Scan upward so the last set bit seen (the highest) wins.
  always_comb begin
    width = '0;
    for (int i = 0; i < CH_W; i++) begin
      if (diff[i]) width = WIDTH_W'(i + 1);
    end
    skip = (diff == '0);
  end

endmodule

// File: rtl/residual_stream.sv
// residual_stream: buffers one pixel block arriving as BEAT_PIX-pixel beats,
// tracks per-channel min/max, derives the block header (min, skip, bits,
// compressable) in one CALC cycle, then streams residuals (pixel - min).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input beat handshake
//   in_pix            BEAT_PIX pixels; pixel p chan c at [(p*CHANNELS+c)*CH_W +: CH_W]
//   in_last           final-beat marker, only checked (err_last), never used for framing
//   out_valid/out_ready output beat handshake
//   out_res           residuals, same packing as in_pix
//   out_first/out_last first/last beat of the block being drained
//   out_min, out_skip, out_bits, out_compressable  block header
//   err_last          one-cycle pulse when in_last disagrees with the beat count
//   dbg_state         current FSM state
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; while valid is high and ready is low the sender holds the beat
// and all side-band fields stable.
module residual_stream
  import residual_stream_pkg::state_t,
         residual_stream_pkg::FILL,
         residual_stream_pkg::CALC,
         residual_stream_pkg::DRAIN;
#(
  parameter int CHANNELS   = residual_stream_pkg::CHANNELS,
  parameter int CH_W       = residual_stream_pkg::CH_W,
  parameter int BLOCK_PIX  = residual_stream_pkg::BLOCK_PIX,
  parameter int BEAT_PIX   = residual_stream_pkg::BEAT_PIX,
  parameter int BIT_BUDGET = residual_stream_pkg::BIT_BUDGET
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BEAT_PIX*CHANNELS*CH_W-1:0]   in_pix,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BEAT_PIX*CHANNELS*CH_W-1:0]   out_res,
  output logic                                out_first,
  output logic                                out_last,
  output logic [CHANNELS*CH_W-1:0]            out_min,
  output logic [CHANNELS-1:0]                 out_skip,
  output logic [CHANNELS*$clog2(CH_W)-1:0]    out_bits,
  output logic                                out_compressable,
  output logic                                err_last,
  output state_t                              dbg_state
);

  localparam int BEATS   = BLOCK_PIX / BEAT_PIX;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W  = BEAT_PIX * CHANNELS * CH_W;
  localparam int BITS_W  = $clog2(CH_W);
  localparam int WIDTH_W = $clog2(CH_W + 1);
  // Wide enough for CHANNELS * CH_W, so the width sum cannot wrap.
  localparam int SUM_W   = $clog2(CHANNELS * CH_W + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  ocnt_q;
  logic [BEAT_W-1:0] beat_buf [BEATS];

  logic [CHANNELS-1:0][CH_W-1:0] min_q, max_q, min_d, max_d;
  logic [CHANNELS-1:0][CH_W-1:0] diff;
  logic [CHANNELS-1:0][WIDTH_W-1:0] width;
  logic [CHANNELS-1:0]           skip;
  logic [SUM_W-1:0]              width_sum;
  logic [CHANNELS*BITS_W-1:0]    calc_bits;
  logic                          calc_comp;

  logic [CHANNELS-1:0][CH_W-1:0] hdr_min_q;
  logic [CHANNELS-1:0]           hdr_skip_q;
  logic [CHANNELS*BITS_W-1:0]    hdr_bits_q;
  logic                          hdr_comp_q;
  logic                          err_last_q;

  logic              in_fire;
  logic              out_fire;
  logic              fill_done;
  logic [BEAT_W-1:0] drain_beat;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fill_done = in_fire && (cnt_q == LAST_BEAT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_done) state_d = CALC;
      CALC:    state_d = DRAIN;
      DRAIN:   if (out_fire && out_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DRAIN);
    out_first = (state_q == DRAIN) && (ocnt_q == '0);
    out_last  = (state_q == DRAIN) && (ocnt_q == LAST_BEAT);
  end

  assign dbg_state = state_q;

  // ------------------------------------------------------ min/max fold
  // The first beat of a block restarts from neutral values so nothing from
  // the previous block leaks into this one.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      min_d[c] = (cnt_q == '0) ? {CH_W{1'b1}} : min_q[c];
      max_d[c] = (cnt_q == '0) ? {CH_W{1'b0}} : max_q[c];
      for (int p = 0; p < BEAT_PIX; p++) begin
        if (in_pix[(p*CHANNELS+c)*CH_W +: CH_W] < min_d[c])
          min_d[c] = in_pix[(p*CHANNELS+c)*CH_W +: CH_W];
        if (in_pix[(p*CHANNELS+c)*CH_W +: CH_W] > max_d[c])
          max_d[c] = in_pix[(p*CHANNELS+c)*CH_W +: CH_W];
      end
    end
  end

  // ------------------------------------------------------ header calc
  genvar gc;
  generate
    for (gc = 0; gc < CHANNELS; gc++) begin : g_ch
      assign diff[gc] = max_q[gc] - min_q[gc];
      ch_width #(.CH_W(CH_W)) u_ch_width (
        .diff  (diff[gc]),
        .width (width[gc]),
        .skip  (skip[gc])
      );
    end
  endgenerate

  always_comb begin
    width_sum = '0;
    calc_bits = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      width_sum = width_sum + SUM_W'(width[c]);
      if (!skip[c])
        calc_bits[c*BITS_W +: BITS_W] = BITS_W'(width[c] - WIDTH_W'(1));
    end
    calc_comp = (width_sum <= SUM_W'(BIT_BUDGET));
  end

  // ------------------------------------------------------ datapath regs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ocnt_q     <= '0;
      min_q      <= {CHANNELS{{CH_W{1'b1}}}};
      max_q      <= '0;
      hdr_min_q  <= '0;
      hdr_skip_q <= '0;
      hdr_bits_q <= '0;
      hdr_comp_q <= 1'b0;
      err_last_q <= 1'b0;
    end else begin
      // Framing follows the count; in_last is only cross-checked.
      err_last_q <= in_fire && (in_last != (cnt_q == LAST_BEAT));
      if (in_fire) begin
        cnt_q <= fill_done ? '0 : cnt_q + CNT_W'(1);
        min_q <= min_d;
        max_q <= max_d;
      end
      if (state_q == CALC) begin
        hdr_min_q  <= min_q;
        hdr_skip_q <= skip;
        hdr_bits_q <= calc_bits;
        hdr_comp_q <= calc_comp;
        ocnt_q     <= '0;
      end
      if (out_fire && !out_last) ocnt_q <= ocnt_q + CNT_W'(1);
    end
  end

  // Block buffer: plain register array, needs no reset since it is only
  // read after being completely rewritten by a FILL phase.
  always_ff @(posedge clk) begin
    if (in_fire) beat_buf[cnt_q] <= in_pix;
  end

  // ------------------------------------------------------ outputs
  assign drain_beat = beat_buf[ocnt_q];

  always_comb begin
    out_res = '0;
    for (int p = 0; p < BEAT_PIX; p++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_res[(p*CHANNELS+c)*CH_W +: CH_W] =
          drain_beat[(p*CHANNELS+c)*CH_W +: CH_W] - hdr_min_q[c];
      end
    end
  end

  assign out_min          = hdr_min_q;
  assign out_skip         = hdr_skip_q;
  assign out_bits         = hdr_bits_q;
  assign out_compressable = hdr_comp_q;
  assign err_last         = err_last_q;

endmodule

// File: doc/residual_stream.md
Name: residual_stream

Overview:
- Streaming, parametrised successor of the single-shot residual stage.
- Accepts one pixel block as a sequence of beats and buffers it locally while tracking per-channel min/max.
- Then computes the per-channel bit widths, skip flags and compressable decision, and streams residuals (pixel minus channel min) out beat-by-beat with the block header.
- Sits between the block fetch stage and the bit packer.

Parameters:
- CHANNELS, 4, colour channels per pixel (RGBA order, channel 0 = R).
- CH_W, 8, bits per channel.
- BLOCK_PIX, 32, pixels per compression block; must be a multiple of BEAT_PIX.
- BEAT_PIX, 4, pixels per input/output beat.
- BIT_BUDGET, 14, maximum summed channel bit widths for the block to be compressable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_pix  in  BEAT_PIX*CHANNELS*CH_W  pixels; pixel p channel c at bits [(p*CHANNELS+c)*CH_W +: CH_W].
- in_last  in  1  marks final beat of block; checked against the internal beat count.
- out_valid  out  1  residual beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_res  out  BEAT_PIX*CHANNELS*CH_W  residuals, same packing as in_pix.
- out_first  out  1  first beat of block.
- out_last  out  1  last beat of block.
- out_min  out  CHANNELS*CH_W  per-channel minimum.
- out_skip  out  CHANNELS  channel c is constant (max == min).
- out_bits  out  CHANNELS*$clog2(CH_W)  per-channel bits_required = width-1, 0 when skipped.
- out_compressable  out  1  sum of widths <= BIT_BUDGET.
- err_last  out  1  one-cycle pulse when in_last disagrees with the beat count.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - state = FILL, beat counter = 0.
  - Min registers = all-ones; max registers = 0.
  - in_ready = 1; out_valid = 0; err_last = 0.
  - out_first, out_last, out_skip, out_bits, out_min and out_compressable = 0.
- Reset mid-block discards all buffered data; no partial output is produced.
- State FILL:
  - in_ready = 1.
  - On each accepted beat: write it to buffer slot cnt; update per-channel min/max across all BEAT_PIX pixels of the beat, including the stored values; cnt += 1.
  - On the first beat of a block (cnt == 0), min/max restart from that beat's values, not the stale registers.
  - When the accepted beat has cnt == BLOCK_PIX/BEAT_PIX-1, go to CALC.
  - in_last is not used for framing. If in_last is high on a non-final beat, or low on the final beat, pulse err_last for one cycle; framing still follows the count.
- State CALC (exactly one cycle, in_ready = 0):
  - diff_c = max_c - min_c, unsigned CH_W bits.
  - width_c = 0 if diff_c == 0, else the index of the highest set bit + 1 (range 1..CH_W).
  - skip_c = (diff_c == 0).
  - bits_c = width_c - 1 when diff_c != 0, else 0, truncated to $clog2(CH_W) bits.
  - compressable = (sum of width_c) <= BIT_BUDGET. The sum is computed at width $clog2(CHANNELS*CH_W+1); it must never wrap.
  - Register the header outputs, reset the output beat counter, go to DRAIN.
- State DRAIN:
  - out_valid = 1. out_res = buffer[ocnt] minus min_c per channel, CH_W bits.
  - out_first = (ocnt == 0); out_last = (ocnt == last).
  - Header outputs are held stable for the whole drain.
  - out_res and all header outputs stay stable while out_valid && !out_ready (backpressure).
  - On a handshake with out_last, go to FILL; out_valid drops the next cycle; in_ready = 1 that cycle.
- Latency: the first out beat is valid 2 cycles after the final input beat is accepted (CALC plus register).
- Throughput: one block per BLOCK_PIX/BEAT_PIX * 2 + 1 cycles with no backpressure; no overlap of FILL and DRAIN.
- Residuals are always non-negative and below 2^width_c by construction.

Decomposition:
- Shared package types:
  - Default constants CHANNELS, CH_W, BLOCK_PIX, BEAT_PIX, BIT_BUDGET.
  - State enum {FILL, CALC, DRAIN}.
  - Header-field width helper constant BITS_W = $clog2(CH_W).
- Sub-module ch_width: combinational, parameter CH_W; input diff; outputs width and skip. Instantiated CHANNELS times.
- The buffer is a register array of BLOCK_PIX/BEAT_PIX beats, not a RAM macro.

Test Plan:
- Constant block: all pixels R=10, G=20, B=30, A=255 -> out_min = {10,20,30,255}, skip = 1111, bits all 0, compressable = 1, every residual 0.
- R spans 5..12, G=G0, B=B0, A=A0 constant -> R diff 7, width 3, bits_R = 2, skip = 0111, compressable = 1, R residuals 0..7.
- All channels span 0..255 -> widths 8 each, sum 32 > 14, compressable = 0, bits = 7 per channel, residuals equal the inputs.
- Widths {4,4,4,2} (sum 14) -> compressable = 1. Widths {4,4,4,3} (sum 15) -> compressable = 0.
- Hold out_ready low for 5 cycles mid-drain -> out_res and header stable; no beat lost or duplicated; 8 beats total with out_first on beat 0 and out_last on beat 7.
- in_last asserted on beat 3 of 8 -> err_last pulses once; the block still completes after 8 beats. Assert rst during DRAIN -> out_valid = 0 and in_ready = 1 the next cycle; the next block's min/max are unaffected by the old block.
